// File: rtl/arp_cache_if.sv
// arp_cache_if - lookup/resolve handshake between a transmit-path client and
// the ARP cache.
//   lookup_req/lookup_ip          client -> cache: lookup strobe and IP
//   lookup_ready                  cache -> client: idle, lookup can be accepted
//   lookup_ack/hit/mac            cache -> client: registered lookup result
//   resolve_done/resolve_fail     cache -> client: outcome of a pending miss
interface arp_cache_if;
   logic        lookup_req;
   logic [31:0] lookup_ip;
   logic        lookup_ready;
   logic        lookup_ack;
   logic        lookup_hit;
   logic [47:0] lookup_mac;
   logic        resolve_done;
   logic        resolve_fail;

   modport master (
      output lookup_req, lookup_ip,
      input  lookup_ready, lookup_ack, lookup_hit, lookup_mac, resolve_done, resolve_fail
   );

   modport slave (
      input  lookup_req, lookup_ip,
      output lookup_ready, lookup_ack, lookup_hit, lookup_mac, resolve_done, resolve_fail
   );
endinterface

// File: rtl/arp_cache.sv
// arp_cache - DEPTH-entry IP-to-MAC cache with aging, replacement and an ARP
// request resolver with timed retries.
//   gmii_clk, rst            clock, async active-high reset
//   lk (slave)               lookup handshake and resolve outcome
//   arp_rx_done_i, src_*_i   learned binding from every received ARP frame
//   arp_tx_en_o, arp_tx_type_o, des_mac_o, des_ip_o   request to the arp block
//   tx_done_i                arp block finished sending
//   flush_i                  invalidate the whole table
//   entry_count_o            number of valid entries
//
// state        | meaning
// S_IDLE       | ready for lookups
// S_SEND       | pulse arp_tx_en with broadcast des_mac
// S_WAIT_TX    | waiting for the arp block to finish the frame
// S_WAIT_REPLY | reply timer running; retry or fail on terminal count
module arp_cache #(
   parameter int DEPTH       = 8,
   parameter int TICK_CYCLES = 125_000_000,
   parameter int AGE_LIMIT   = 300,
   parameter int ATTEMPTS    = 3,
   parameter int REPLY_WAIT  = 125_000
) (
   input  logic                       gmii_clk,
   input  logic                       rst,
   arp_cache_if.slave                 lk,
   input  logic                       arp_rx_done_i,
   input  logic [47:0]                src_mac_i,
   input  logic [31:0]                src_ip_i,
   input  logic                       tx_done_i,
   input  logic                       flush_i,
   output logic                       arp_tx_en_o,
   output logic                       arp_tx_type_o,
   output logic [47:0]                des_mac_o,
   output logic [31:0]                des_ip_o,
   output logic [$clog2(DEPTH+1)-1:0] entry_count_o
);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH+1);
   localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int RW_W   = (REPLY_WAIT > 1) ? $clog2(REPLY_WAIT) : 1;
   localparam logic [15:0] AGE_LIM = 16'(AGE_LIMIT);
   localparam logic [3:0]  ATT_MAX = 4'(ATTEMPTS);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_TX, S_WAIT_REPLY} state_t;

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [31:0]       ip_q  [DEPTH];
   logic [31:0]       ip_d  [DEPTH];
   logic [47:0]       mac_q [DEPTH];
   logic [47:0]       mac_d [DEPTH];
   logic [15:0]       age_q [DEPTH];
   logic [15:0]       age_d [DEPTH];
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TICK_W-1:0] tick_q;
   logic              tick_wrap;
   logic              learn;

   logic              hit_found, free_found;
   logic [IDX_W-1:0]  hit_idx, free_idx, old_idx, wr_idx;
   logic [15:0]       old_age;

   logic              lk_hit;
   logic [47:0]       lk_mac;

   state_t            state_q;
   logic [3:0]        att_q;
   logic [RW_W-1:0]   timer_q;
   logic              ack_q, hit_q, done_q, fail_q, tx_en_q;
   logic [47:0]       lk_mac_q, des_mac_q;
   logic [31:0]       des_ip_q;
   logic              resolved;

   assign tick_wrap = (tick_q == '0);
   // flush wins over a simultaneous learn
   assign learn     = arp_rx_done_i & ~flush_i;
   assign resolved  = learn && (src_ip_i == des_ip_q);

   // Aging is applied first so a learn into a full table can reuse a slot
   // that expires in the same cycle.
   always_comb begin
      valid_d    = valid_q;
      ip_d       = ip_q;
      mac_d      = mac_q;
      age_d      = age_q;
      hit_found  = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      wr_idx     = '0;
      cnt_d      = '0;
      if (tick_wrap) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
               age_d[i] = (age_q[i] == 16'hffff) ? age_q[i] : age_q[i] + 16'd1;
               if (age_d[i] == AGE_LIM) valid_d[i] = 1'b0;
            end
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_d[i] && ip_d[i] == src_ip_i && !hit_found) begin
            hit_found = 1'b1;
            hit_idx   = IDX_W'(i);
         end
         if (!valid_d[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
      // oldest entry, strict compare keeps the lowest index on ties
      old_idx = '0;
      old_age = age_d[0];
      for (int i = 1; i < DEPTH; i++) begin
         if (age_d[i] > old_age) begin
            old_age = age_d[i];
            old_idx = IDX_W'(i);
         end
      end
      if (learn) begin
         wr_idx          = hit_found ? hit_idx : (free_found ? free_idx : old_idx);
         valid_d[wr_idx] = 1'b1;
         ip_d[wr_idx]    = src_ip_i;
         mac_d[wr_idx]   = src_mac_i;
         age_d[wr_idx]   = '0;
      end
      if (flush_i) valid_d = '0;
      for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + CNT_W'(valid_d[i]);
   end

   // Parallel compare; a same-cycle learn of the looked-up IP bypasses the table.
   always_comb begin
      lk_hit = 1'b0;
      lk_mac = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && ip_q[i] == lk.lookup_ip) begin
            lk_hit = 1'b1;
            lk_mac = mac_q[i];
         end
      end
      if (learn && src_ip_i == lk.lookup_ip) begin
         lk_hit = 1'b1;
         lk_mac = src_mac_i;
      end
   end

   always_ff @(posedge gmii_clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         cnt_q   <= '0;
         tick_q  <= TICK_W'(TICK_CYCLES - 1);
         for (int i = 0; i < DEPTH; i++) begin
            ip_q[i]  <= '0;
            mac_q[i] <= '0;
            age_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         ip_q    <= ip_d;
         mac_q   <= mac_d;
         age_q   <= age_d;
         cnt_q   <= cnt_d;
         tick_q  <= tick_wrap ? TICK_W'(TICK_CYCLES - 1) : tick_q - TICK_W'(1);
      end
   end

   always_ff @(posedge gmii_clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         att_q     <= '0;
         timer_q   <= '0;
         ack_q     <= 1'b0;
         hit_q     <= 1'b0;
         done_q    <= 1'b0;
         fail_q    <= 1'b0;
         tx_en_q   <= 1'b0;
         lk_mac_q  <= '0;
         des_mac_q <= '0;
         des_ip_q  <= '0;
      end else begin
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
         tx_en_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (lk.lookup_req) begin
                  ack_q    <= 1'b1;
                  hit_q    <= lk_hit;
                  lk_mac_q <= lk_mac;
                  if (!lk_hit) begin
                     state_q  <= S_SEND;
                     att_q    <= 4'd1;
                     des_ip_q <= lk.lookup_ip;
                  end
               end
            end
            S_SEND: begin
               tx_en_q   <= 1'b1;
               des_mac_q <= '1;
               state_q   <= S_WAIT_TX;
            end
            S_WAIT_TX: begin
               if (resolved) begin
                  done_q   <= 1'b1;
                  lk_mac_q <= src_mac_i;
                  state_q  <= S_IDLE;
               end else if (tx_done_i) begin
                  timer_q <= RW_W'(REPLY_WAIT - 1);
                  state_q <= S_WAIT_REPLY;
               end
            end
            S_WAIT_REPLY: begin
               if (resolved) begin
                  done_q   <= 1'b1;
                  lk_mac_q <= src_mac_i;
                  state_q  <= S_IDLE;
               end else if (timer_q == '0) begin
                  if (att_q < ATT_MAX) begin
                     att_q   <= att_q + 4'd1;
                     state_q <= S_SEND;
                  end else begin
                     fail_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end else begin
                  timer_q <= timer_q - RW_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign lk.lookup_ready = (state_q == S_IDLE);
   assign lk.lookup_ack   = ack_q;
   assign lk.lookup_hit   = hit_q;
   assign lk.lookup_mac   = lk_mac_q;
   assign lk.resolve_done = done_q;
   assign lk.resolve_fail = fail_q;
   assign arp_tx_en_o     = tx_en_q;
   assign arp_tx_type_o   = 1'b0;
   assign des_mac_o       = des_mac_q;
   assign des_ip_o        = des_ip_q;
   assign entry_count_o   = cnt_q;
endmodule

// File: doc/arp_cache.md
# arp_cache

Multi-entry IP-to-MAC resolution cache sitting between the `arp` block (rx/tx, CRC32) and the UDP/TRDP transmit path. It learns bindings from every received ARP frame, ages them out, and serves single-cycle lookups. On a miss it drives `arp` to broadcast ARP requests with timed retries until the binding is learned or the attempt budget is exhausted. It generalises the single fixed-destination ARP flow to DEPTH destinations, with aging, replacement and retry behaviour.

## Interface
- DEPTH, 8: table entries; power of two, 2..32.
- TICK_CYCLES, 125_000_000: gmii_clk cycles per age tick.
- AGE_LIMIT, 300: ticks after which an unrefreshed entry is invalidated; 1..65535.
- ATTEMPTS, 3: total ARP requests sent per miss before failure; 1..15.
- REPLY_WAIT, 125_000: cycles to wait for a reply after each `tx_done`.

- gmii_clk  in  1  single clock for the whole block.
- rst  in  1  reset, asynchronous, active-high.
- arp_rx_done  in  1  one-cycle pulse: `src_mac`/`src_ip` are valid.
- src_mac  in  48  sender MAC of received ARP frame.
- src_ip  in  32  sender IP of received ARP frame.
- lookup_req  in  1  lookup strobe; accepted only while `lookup_ready`=1.
- lookup_ip  in  32  IP to resolve; sampled on accept.
- lookup_ready  out  1  high when idle and able to accept a lookup.
- lookup_ack  out  1  one-cycle pulse: result valid.
- lookup_hit  out  1  entry found; qualified by `lookup_ack`.
- lookup_mac  out  48  resolved MAC; valid with `lookup_ack` and `lookup_hit`.
- resolve_done  out  1  one-cycle pulse: pending miss resolved; `lookup_mac` holds the MAC.
- resolve_fail  out  1  one-cycle pulse: all attempts exhausted.
- arp_tx_en  out  1  one-cycle pulse to `arp`: start transmission.
- arp_tx_type  out  1  0 = request; always 0 from this block.
- des_mac  out  48  48'hff_ff_ff_ff_ff_ff whenever `arp_tx_en` pulses.
- des_ip  out  32  pending IP being resolved.
- tx_done  in  1  one-cycle pulse from `arp`: frame sent.
- flush  in  1  invalidate all entries.
- entry_count  out  $clog2(DEPTH+1)  number of valid entries.

## Operation
- Entry: valid, ip[31:0], mac[47:0], age[15:0].
- Learn (on `arp_rx_done`, request or reply): if `src_ip` matches a valid entry, overwrite MAC, age:=0. Else write the lowest-index invalid entry. If full, replace the entry with the greatest age (tie: lowest index). Learn never changes `entry_count` on replace.
- Aging: free-running tick counter 0..TICK_CYCLES-1; on wrap every valid entry age+1 (saturating at 65535); an entry whose incremented age equals AGE_LIMIT is invalidated in the same cycle. Lookup hits do not refresh age.
- Lookup: parallel compare of `lookup_ip` against all valid entries.
- Resolver FSM: IDLE -> (miss) SEND -> WAIT_TX -> WAIT_REPLY -> SEND (retry) or IDLE.
  - IDLE: `lookup_ready`=1. Hit -> stay. Miss -> SEND, attempt count:=1, `des_ip`:=lookup_ip.
  - SEND: `arp_tx_en`=1 for exactly one cycle, `des_mac`=all-ones -> WAIT_TX.
  - WAIT_TX: wait for `tx_done` -> WAIT_REPLY, reply timer:=0.
  - WAIT_REPLY: timer reaching REPLY_WAIT-1: if attempts < ATTEMPTS, attempt+1 -> SEND; else pulse `resolve_fail` -> IDLE.
  - In WAIT_TX or WAIT_REPLY, a learn whose `src_ip`==`des_ip` pulses `resolve_done` with `lookup_mac`:=src_mac -> IDLE in the next cycle; a pending `tx_done` is then ignored.
- Flush: all valid:=0, `entry_count`:=0; resolver state unaffected.
- Simultaneous: learn + lookup of same IP in one cycle -> hit with `src_mac` (bypass). Flush + learn -> flush wins, learn dropped. Learn into a full table + aging invalidation in one cycle -> aging applied first, learn takes the freed slot.
- Reset mid-resolution: FSM to IDLE, table cleared, no `resolve_*` pulse.

## Timing
- Reset values: `lookup_ready`=1 after reset release; all other outputs 0, including `des_mac`/`des_ip`/`lookup_mac`.
- Lookup accepted at edge T -> `lookup_ack`, `lookup_hit`, `lookup_mac` valid at T+1 (registered). `lookup_ready` low from T+1 on a miss.
- Miss: `arp_tx_en` pulse at T+2.
- Learn visible to lookups at the edge after `arp_rx_done`; `entry_count` updates the same cycle.
- `resolve_done` is asserted 1 cycle after the matching `arp_rx_done`; `lookup_ready`=1 the following cycle.

## Test plan
- Inject `arp_rx_done` with IP 192.168.1.20, MAC 00:0a:35:00:01:02; lookup 192.168.1.20 -> `lookup_ack`+`lookup_hit` at T+1, MAC 00:0a:35:00:01:02, `entry_count`=1.
- Lookup 192.168.1.30 on empty table -> hit=0, `arp_tx_en` at T+2 with `des_ip`=c0a8011e, `des_mac`=ffffffffffff; after `tx_done` inject a reply from .30 -> `resolve_done`, `lookup_mac` correct.
- Miss with no reply, ATTEMPTS=3, REPLY_WAIT=100 -> exactly 3 `arp_tx_en` pulses, each 100 cycles after `tx_done`, then one `resolve_fail`.
- DEPTH=4: learn 4 IPs, age entry 2 highest, learn a 5th -> entry 2 replaced, `entry_count` stays 4, old IP misses.
- TICK_CYCLES=10, AGE_LIMIT=3: learn, idle 30 cycles -> entry invalid, `entry_count`=0; `flush` after 2 learns -> `entry_count`=0, lookups miss.
- Same-cycle learn and lookup of .40 -> hit with the new MAC; assert `rst` during WAIT_REPLY -> all outputs return to reset values, no `resolve_*` pulse.
